// File: rtl/bus_select_mux_pkg.sv
// Shared definitions for the bus_select_mux slice: default word width and word-packing helper.
`default_nettype none

package bus_select_mux_pkg;

   localparam int DEFAULT_BUS_SIZE = 32;

   // Low bit of packed word 'idx' when every word is 'bus_size' bits wide.
   function automatic int word_lsb(input int idx, input int bus_size);
      return idx * bus_size;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bus_select_mux_pipe_reg.sv
// pipe_reg: single-stage register, asynchronous active-low reset to zero, no enable.
`default_nettype none

module pipe_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bus_select_mux.sv
// bus_select_mux: combinational N-way word selector with out-of-range flag and a registered copy.
`default_nettype none

module bus_select_mux
   import bus_select_mux_pkg::*;
#(
   parameter int BITS_ENABLES = 1,
   parameter int BUS_SIZE     = DEFAULT_BUS_SIZE,
   parameter int NUM_INPUTS   = 2**BITS_ENABLES
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [BITS_ENABLES-1:0]        i_en,
   input  logic [NUM_INPUTS*BUS_SIZE-1:0] i_data,
   output logic [BUS_SIZE-1:0]            o_data,
   output logic                           o_sel_err,
   output logic [BUS_SIZE-1:0]            o_data_q,
   output logic                           o_sel_err_q
);

   localparam int DEPTH = 2**BITS_ENABLES;
   localparam logic [BITS_ENABLES:0] NUM_INPUTS_W = NUM_INPUTS[BITS_ENABLES:0];

   if (NUM_INPUTS < 2) begin : g_chk_min_inputs
      $error("bus_select_mux: NUM_INPUTS must be at least 2");
   end
   if (NUM_INPUTS > DEPTH) begin : g_chk_max_inputs
      $error("bus_select_mux: NUM_INPUTS exceeds 2**BITS_ENABLES");
   end
   if (BUS_SIZE < 1) begin : g_chk_bus_size
      $error("bus_select_mux: BUS_SIZE must be at least 1");
   end

   // The table is padded to the full select range with zero words, so an
   // out-of-range index reads 0 and the index never needs a bounds guard.
   logic [BUS_SIZE-1:0] words [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_word
      if (k < NUM_INPUTS) begin : g_live
         assign words[k] = i_data[word_lsb(k, BUS_SIZE) +: BUS_SIZE];
      end else begin : g_pad
         assign words[k] = '0;
      end
   end

   logic [BITS_ENABLES:0] en_ext;
   logic [BUS_SIZE:0]     pipe_d;
   logic [BUS_SIZE:0]     pipe_q;

   assign en_ext    = {1'b0, i_en};
   assign o_data    = words[i_en];
   assign o_sel_err = (en_ext >= NUM_INPUTS_W);

   assign pipe_d = {o_sel_err, o_data};

   pipe_reg #(
      .WIDTH (BUS_SIZE + 1)
   ) u_pipe_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pipe_d),
      .q     (pipe_q)
   );

   assign o_data_q    = pipe_q[BUS_SIZE-1:0];
   assign o_sel_err_q = pipe_q[BUS_SIZE];

endmodule

`default_nettype wire

// File: tb/tb_bus_select_mux.sv
// Directed and randomised checks of bus_select_mux in three parameterisations.
`default_nettype none

module tb_bus_select_mux;

   logic clk;
   logic rst_n;

   // Default configuration: 2 x 32-bit words.
   logic        en0;
   logic [63:0] data0;
   logic [31:0] out0, out0_q;
   logic        err0, err0_q;

   // 2-bit select, 3 words: index 3 is out of range.
   logic [1:0]  en1;
   logic [95:0] data1;
   logic [31:0] out1, out1_q;
   logic        err1, err1_q;

   // 3-bit select, 8 x 8-bit words for the random sweep.
   logic [2:0]  en2;
   logic [63:0] data2;
   logic [7:0]  out2, out2_q;
   logic        err2, err2_q;

   int checks = 0;
   int errors = 0;

   bus_select_mux u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_en(en0), .i_data(data0),
      .o_data(out0), .o_sel_err(err0), .o_data_q(out0_q), .o_sel_err_q(err0_q)
   );

   bus_select_mux #(.BITS_ENABLES(2), .BUS_SIZE(32), .NUM_INPUTS(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_en(en1), .i_data(data1),
      .o_data(out1), .o_sel_err(err1), .o_data_q(out1_q), .o_sel_err_q(err1_q)
   );

   bus_select_mux #(.BITS_ENABLES(3), .BUS_SIZE(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_en(en2), .i_data(data2),
      .o_data(out2), .o_sel_err(err2), .o_data_q(out2_q), .o_sel_err_q(err2_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] ref2;

      rst_n = 1'b0;
      en0   = 1'b0;
      data0 = {32'hDEADBEEF, 32'h00000005};
      en1   = 2'd0;
      data1 = {32'd3, 32'd2, 32'd1};
      en2   = 3'd0;
      data2 = 64'h0;

      // Registered outputs stay zero while held in reset, even across edges.
      repeat (2) after_edge();
      check("rst_data_q0", out0_q, 64'h0);
      check("rst_err_q0",  err0_q, 64'h0);
      check("rst_err_q1",  err1_q, 64'h0);
      check("rst_comb_live", out0, 64'h5);

      @(negedge clk);
      rst_n = 1'b1;

      // Combinational selection, default parameters.
      en0 = 1'b0; #1;
      check("sel0_data", out0, 64'h5);
      check("sel0_err",  err0, 64'h0);
      en0 = 1'b1; #1;
      check("sel1_data", out0, 64'hDEADBEEF);
      check("sel1_err",  err0, 64'h0);

      // Registered path: each edge captures the value present at that edge.
      @(negedge clk); en0 = 1'b0;
      after_edge();
      check("pipe_0", out0_q, 64'h5);
      en0 = 1'b1;
      after_edge();
      check("pipe_1", out0_q, 64'hDEADBEEF);
      check("pipe_1_err", err0_q, 64'h0);
      en0 = 1'b0;
      after_edge();
      check("pipe_2", out0_q, 64'h5);
      en0 = 1'b1;
      after_edge();
      check("pipe_3", out0_q, 64'hDEADBEEF);

      // Asynchronous reset between edges.
      @(negedge clk);
      rst_n = 1'b0; #1;
      check("async_rst_data_q", out0_q, 64'h0);
      check("async_rst_err_q",  err0_q, 64'h0);
      check("async_rst_comb",   out0,   64'hDEADBEEF);
      after_edge();
      check("rst_hold_data_q", out0_q, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      en0   = 1'b0; #1;
      check("rel_no_clk_q", out0_q, 64'h0);
      after_edge();
      check("rel_first_cap", out0_q, 64'h5);

      // Three words with a 2-bit select.
      en1 = 2'd0; #1;
      check("n3_sel0", out1, 64'd1);
      check("n3_err0", err1, 64'd0);
      en1 = 2'd1; #1;
      check("n3_sel1", out1, 64'd2);
      en1 = 2'd2; #1;
      check("n3_sel2", out1, 64'd3);
      check("n3_err2", err1, 64'd0);
      en1 = 2'd3; #1;
      check("n3_oor_data", out1, 64'd0);
      check("n3_oor_err",  err1, 64'd1);
      after_edge();
      check("n3_oor_err_q",  err1_q, 64'd1);
      check("n3_oor_data_q", out1_q, 64'd0);
      en1 = 2'd2;
      after_edge();
      check("n3_back_err_q",  err1_q, 64'd0);
      check("n3_back_data_q", out1_q, 64'd3);

      // Random sweep: comb output against the reference slice, then its capture.
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         data2 = {$urandom, $urandom};
         en2   = 3'($urandom_range(0, 7));
         ref2  = 8'(data2 >> (32'(en2) * 8));
         #1;
         check("rand_comb", out2, 64'(ref2));
         check("rand_err",  err2, 64'h0);
         after_edge();
         check("rand_q", out2_q, 64'(ref2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
